// File: rtl/frequency_divider.sv
// Registered note-divisor table for the tone generators: twelve semitone period counts at 10 MHz.
// Optional macro FREQ_DIV_ROUND_EN selects round-half-up shifting instead of truncation.
module frequency_divider #(
  parameter int unsigned BASE_SHIFT = 0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        octave,
  output logic [15:0] div0,
  output logic [15:0] div1,
  output logic [15:0] div2,
  output logic [15:0] div3,
  output logic [15:0] div4,
  output logic [15:0] div5,
  output logic [15:0] div6,
  output logic [15:0] div7,
  output logic [15:0] div8,
  output logic [15:0] div9,
  output logic [15:0] div10,
  output logic [15:0] div11,
  output logic        changed
);

  localparam int unsigned NUM_NOTES = 12;
  localparam int unsigned DIV_W     = 16;
  localparam int unsigned SHIFT_W   = 3;

  // Octave-4 period counts, round(10e6 / f), C through B.
  function automatic logic [DIV_W-1:0] base_of(input logic [3:0] idx);
    logic [DIV_W-1:0] val;
    val = '0;
    case (idx)
      4'd0:    val = 16'd38222;
      4'd1:    val = 16'd36077;
      4'd2:    val = 16'd34052;
      4'd3:    val = 16'd32141;
      4'd4:    val = 16'd30337;
      4'd5:    val = 16'd28634;
      4'd6:    val = 16'd27027;
      4'd7:    val = 16'd25511;
      4'd8:    val = 16'd24079;
      4'd9:    val = 16'd22727;
      4'd10:   val = 16'd21452;
      4'd11:   val = 16'd20248;
      default: val = '0;
    endcase
    return val;
  endfunction

  logic [SHIFT_W-1:0] s;
  logic [SHIFT_W-1:0] last_s;
  logic               loaded;
  logic [DIV_W:0]     half;
  logic [DIV_W-1:0]   div_d [NUM_NOTES];
  logic [DIV_W-1:0]   div_q [NUM_NOTES];

  assign s = SHIFT_W'(BASE_SHIFT) + SHIFT_W'(octave);

  // Rounding bias: half an LSB of the shifted result, zero when there is no shift.
  always_comb begin
    half = '0;
`ifdef FREQ_DIV_ROUND_EN
    if (s != '0) begin
      half = (DIV_W+1)'(1) << (s - SHIFT_W'(1));
    end
`endif
  end

  always_comb begin
    for (int k = 0; k < NUM_NOTES; k++) begin
      div_d[k] = DIV_W'(({1'b0, base_of(4'(k))} + half) >> s);
    end
  end

  // Table reloads every cycle; changed flags the first load and any shift change.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      for (int k = 0; k < NUM_NOTES; k++) begin
        div_q[k] <= '0;
      end
      last_s  <= '0;
      loaded  <= 1'b0;
      changed <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_NOTES; k++) begin
        div_q[k] <= div_d[k];
      end
      last_s  <= s;
      loaded  <= 1'b1;
      changed <= !loaded || (s != last_s);
    end
  end

  assign div0  = div_q[0];
  assign div1  = div_q[1];
  assign div2  = div_q[2];
  assign div3  = div_q[3];
  assign div4  = div_q[4];
  assign div5  = div_q[5];
  assign div6  = div_q[6];
  assign div7  = div_q[7];
  assign div8  = div_q[8];
  assign div9  = div_q[9];
  assign div10 = div_q[10];
  assign div11 = div_q[11];

endmodule

// File: tb/tb_frequency_divider.sv
// Directed bench for frequency_divider: default instance plus a BASE_SHIFT=3 instance.
// Expected tables are hand-computed; FREQ_DIV_ROUND_EN selects the rounded tables.
module tb_frequency_divider;

  logic        clk;
  logic        clk_en;
  logic        nrst;
  logic        octave;
  logic [15:0] a_div [12];
  logic [15:0] b_div [12];
  logic        a_changed;
  logic        b_changed;

  int errors;
  int checks;

  logic [15:0] base_t [12];
  logic [15:0] half_t [12];
  logic [15:0] sh4_t  [12];

  typedef struct {
    logic octave;
    logic half;
    logic ch;
  } vec_t;

  vec_t vecs [13];

  frequency_divider #(.BASE_SHIFT(0)) dut_a (
    .clk(clk), .nrst(nrst), .octave(octave),
    .div0(a_div[0]), .div1(a_div[1]), .div2(a_div[2]), .div3(a_div[3]),
    .div4(a_div[4]), .div5(a_div[5]), .div6(a_div[6]), .div7(a_div[7]),
    .div8(a_div[8]), .div9(a_div[9]), .div10(a_div[10]), .div11(a_div[11]),
    .changed(a_changed)
  );

  frequency_divider #(.BASE_SHIFT(3)) dut_b (
    .clk(clk), .nrst(nrst), .octave(octave),
    .div0(b_div[0]), .div1(b_div[1]), .div2(b_div[2]), .div3(b_div[3]),
    .div4(b_div[4]), .div5(b_div[5]), .div6(b_div[6]), .div7(b_div[7]),
    .div8(b_div[8]), .div9(b_div[9]), .div10(b_div[10]), .div11(b_div[11]),
    .changed(b_changed)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic half, input logic ch);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("%s div%0d", tag, k), a_div[k], half ? half_t[k] : base_t[k]);
    end
    check($sformatf("%s changed", tag), 16'(a_changed), 16'(ch));
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("%s a_div%0d", tag, k), a_div[k], 16'd0);
      check($sformatf("%s b_div%0d", tag, k), b_div[k], 16'd0);
    end
    check($sformatf("%s a_changed", tag), 16'(a_changed), 16'd0);
    check($sformatf("%s b_changed", tag), 16'(b_changed), 16'd0);
  endtask

  task automatic check_b_sh4(input string tag);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("%s b_div%0d", tag, k), b_div[k], sh4_t[k]);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clk_en = 1'b0;
    nrst   = 1'b0;
    octave = 1'b0;

    base_t = '{16'd38222, 16'd36077, 16'd34052, 16'd32141, 16'd30337, 16'd28634,
               16'd27027, 16'd25511, 16'd24079, 16'd22727, 16'd21452, 16'd20248};
`ifdef FREQ_DIV_ROUND_EN
    half_t = '{16'd19111, 16'd18039, 16'd17026, 16'd16071, 16'd15169, 16'd14317,
               16'd13514, 16'd12756, 16'd12040, 16'd11364, 16'd10726, 16'd10124};
    sh4_t  = '{16'd2389, 16'd2255, 16'd2128, 16'd2009, 16'd1896, 16'd1790,
               16'd1689, 16'd1594, 16'd1505, 16'd1420, 16'd1341, 16'd1266};
`else
    half_t = '{16'd19111, 16'd18038, 16'd17026, 16'd16070, 16'd15168, 16'd14317,
               16'd13513, 16'd12755, 16'd12039, 16'd11363, 16'd10726, 16'd10124};
    sh4_t  = '{16'd2388, 16'd2254, 16'd2128, 16'd2008, 16'd1896, 16'd1789,
               16'd1689, 16'd1594, 16'd1504, 16'd1420, 16'd1340, 16'd1265};
`endif

    // steady base, switch up and hold, then toggle every cycle
    vecs[0]  = '{octave: 1'b0, half: 1'b0, ch: 1'b1};
    vecs[1]  = '{octave: 1'b0, half: 1'b0, ch: 1'b0};
    vecs[2]  = '{octave: 1'b1, half: 1'b1, ch: 1'b1};
    vecs[3]  = '{octave: 1'b1, half: 1'b1, ch: 1'b0};
    vecs[4]  = '{octave: 1'b1, half: 1'b1, ch: 1'b0};
    for (int i = 0; i < 8; i++) begin
      vecs[5+i] = '{octave: 1'(i % 2 == 0 ? 0 : 1), half: 1'(i % 2 == 0 ? 0 : 1), ch: 1'b1};
    end

    // Asynchronous reset with the clock stopped
    #1 nrst = 1'b1;
    #1 check_zero("reset_noclk");

    #2 nrst = 1'b0;
    clk_en = 1'b1;

    for (int i = 0; i < 13; i++) begin
      octave = vecs[i].octave;
      step();
      check_a($sformatf("vec%0d", i), vecs[i].half, vecs[i].ch);
      if (vecs[i].octave) check_b_sh4($sformatf("vec%0d", i));
    end

    // Octave glitch that never reaches a clock edge
    octave = 1'b1;
    step();
    step();
    check_a("hold1", 1'b1, 1'b0);
    #2 octave = 1'b0;
    #2 octave = 1'b1;
    step();
    check_a("glitch", 1'b1, 1'b0);
    check_b_sh4("glitch");

    // Reset pulse mid-run: immediate zeros, then restore on first edge
    #1 nrst = 1'b1;
    #1 check_zero("reset_midrun");
    step();
    check_zero("reset_held");
    nrst = 1'b0;
    step();
    check_a("restore", 1'b1, 1'b1);
    check_b_sh4("restore");
    check("restore b_changed", 16'(b_changed), 16'd1);
    step();
    check_a("restore_hold", 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
